// File: rtl/match_record_fifo.sv
// Turns each new matcher report into a (start,end) record held in a first-word-fall-through FIFO.
// Record visible on rd_* one clock after the event edge; events arriving while full are dropped and flagged.
// Optional length filter (drops records shorter than MIN_LEN) enabled with `define MATCH_LEN_FILTER_EN.
module match_record_fifo #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int POS_W   = 32,
  parameter int MIN_LEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rdy,
  input  logic              match,
  input  logic [POS_W-1:0]  startPos,
  input  logic [POS_W-1:0]  endPos,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [POS_W-1:0]  rd_start,
  output logic [POS_W-1:0]  rd_end,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [15:0]       total_events
);

  localparam logic [POS_W-1:0]  NONE     = '1;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [POS_W-1:0]  r_mem_start [DEPTH];
  logic [POS_W-1:0]  r_mem_end   [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [15:0]       r_total;
  logic              r_prev_match;
  logic [POS_W-1:0]  r_last_start;
  logic [POS_W-1:0]  r_last_end;
  logic [POS_W-1:0]  r_hold_start;
  logic [POS_W-1:0]  r_hold_end;

  logic w_new_pair;
  logic w_event;
  logic w_len_ok;
  logic w_record;
  logic w_pop;
  logic w_write;
  logic w_drop;

  // A held match only reports again once the position pair changes.
  assign w_new_pair = ~r_prev_match | (startPos != r_last_start) | (endPos != r_last_end);
  assign w_event    = rdy & match & w_new_pair & (startPos != NONE) & (endPos != NONE)
                    & (endPos >= startPos);

`ifdef MATCH_LEN_FILTER_EN
  logic [POS_W:0] w_len;
  assign w_len    = {1'b0, endPos} - {1'b0, startPos} + (POS_W+1)'(1);
  assign w_len_ok = (w_len >= (POS_W+1)'(MIN_LEN));
`else
  logic w_unused_min_len;
  assign w_unused_min_len = |MIN_LEN;
  assign w_len_ok         = 1'b1;
`endif

  assign w_record = w_event & w_len_ok;
  assign w_pop    = rd_en & ~empty;
  assign w_write  = w_record & (~full | w_pop);
  assign w_drop   = w_record & full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!clr && w_write) begin
      r_mem_start[r_wr_ptr] <= startPos;
      r_mem_end[r_wr_ptr]   <= endPos;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_total      <= '0;
      r_prev_match <= 1'b0;
      r_last_start <= '1;
      r_last_end   <= '1;
      r_hold_start <= '0;
      r_hold_end   <= '0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_total      <= '0;
      r_prev_match <= 1'b0;
      r_last_start <= '1;
      r_last_end   <= '1;
      r_hold_start <= '0;
      r_hold_end   <= '0;
    end else begin
      r_prev_match <= rdy & match;
      if (w_event) begin
        r_last_start <= startPos;
        r_last_end   <= endPos;
      end
      if (w_record && r_total != 16'hFFFF) r_total <= r_total + 16'd1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_write) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      // The popped head is kept so rd_* still shows it once the FIFO drains.
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + ADDR_W'(1);
        r_hold_start <= r_mem_start[r_rd_ptr];
        r_hold_end   <= r_mem_end[r_rd_ptr];
      end
      unique case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == FULL_CNT);
  assign rd_valid     = ~empty;
  assign overflow     = r_overflow;
  assign total_events = r_total;
  assign rd_start     = empty ? r_hold_start : r_mem_start[r_rd_ptr];
  assign rd_end       = empty ? r_hold_end   : r_mem_end[r_rd_ptr];

endmodule

// File: tb/tb_match_record_fifo.sv
// Bench for match_record_fifo: directed test-plan scenarios plus randomized traffic against a queue model.
module tb_match_record_fifo;

  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  localparam int POS_W = 32;
`ifdef MATCH_LEN_FILTER_EN
  localparam int TB_MIN_LEN = 4;
`else
  localparam int TB_MIN_LEN = 1;
`endif
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic rdy = 1'b0;
  logic match = 1'b0;
  logic [31:0] startPos = '0;
  logic [31:0] endPos = '0;
  logic rd_en = 1'b0;
  logic rd_valid;
  logic [31:0] rd_start;
  logic [31:0] rd_end;
  logic [3:0] count;
  logic full;
  logic empty;
  logic overflow;
  logic [15:0] total_events;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] q[$];
  logic        m_prev;
  logic [31:0] m_ls, m_le, m_hs, m_he;
  logic        m_ovf;
  int          m_tot;

  match_record_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POS_W(POS_W), .MIN_LEN(TB_MIN_LEN)) dut (
    .clk(clk), .reset(reset), .clr(clr), .rdy(rdy), .match(match),
    .startPos(startPos), .endPos(endPos), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_start(rd_start), .rd_end(rd_end), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .total_events(total_events)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic m_reset();
    q.delete();
    m_prev = 1'b0; m_ls = ONES; m_le = ONES;
    m_hs = '0; m_he = '0; m_ovf = 1'b0; m_tot = 0;
  endtask

  // Applies one clock edge of the spec's rules to the model using the current inputs.
  task automatic m_step();
    bit evt, keep, pop;
    if (!reset || clr) begin
      m_reset();
      return;
    end
    evt = rdy && match && (!m_prev || startPos != m_ls || endPos != m_le) &&
          startPos != ONES && endPos != ONES && endPos >= startPos;
    keep = evt && ((longint'(endPos) - longint'(startPos) + 1) >= TB_MIN_LEN);
    pop = rd_en && q.size() > 0;
    if (pop) begin
      m_hs = q[0][63:32]; m_he = q[0][31:0];
      void'(q.pop_front());
    end
    if (keep) begin
      if (m_tot < 65535) m_tot++;
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back({startPos, endPos});
    end
    m_prev = rdy && match;
    if (evt) begin m_ls = startPos; m_le = endPos; end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    match = 1'b0; rd_en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_reset();
    #12;
    n_cmp++; if ({rd_valid, empty, full, count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin n_bad++;
      $display("FAIL reset_flags got valid=%b empty=%b full=%b count=%0d want 0 1 0 0", rd_valid, empty, full, count); end
    n_cmp++; if ({rd_start, rd_end} !== 64'd0) begin n_bad++;
      $display("FAIL reset_rd got %h/%h want 0/0", rd_start, rd_end); end
    n_cmp++; if ({overflow, total_events} !== 17'd0) begin n_bad++;
      $display("FAIL reset_stats got ovf=%b tot=%0d want 0 0", overflow, total_events); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_held_match();
    rdy = 1'b1; match = 1'b1; startPos = 32'd0; endPos = 32'd3;
    repeat (5) tick();
    n_cmp++; if ({count, total_events} !== {4'd1, 16'd1}) begin n_bad++;
      $display("FAIL held_single got count=%0d tot=%0d want 1 1", count, total_events); end
    n_cmp++; if ({rd_valid, rd_start, rd_end} !== {1'b1, 32'd0, 32'd3}) begin n_bad++;
      $display("FAIL held_head got v=%b %0d/%0d want 1 0/3", rd_valid, rd_start, rd_end); end
  endtask

  task automatic test_changed_end();
    endPos = 32'd5;
    tick();
    match = 1'b0;
    n_cmp++; if ({count, total_events} !== {4'd2, 16'd2}) begin n_bad++;
      $display("FAIL change_count got count=%0d tot=%0d want 2 2", count, total_events); end
    n_cmp++; if ({rd_start, rd_end} !== {32'd0, 32'd3}) begin n_bad++;
      $display("FAIL pop1_head got %0d/%0d want 0/3", rd_start, rd_end); end
    rd_en = 1'b1; tick();
    n_cmp++; if ({rd_start, rd_end} !== {32'd0, 32'd5}) begin n_bad++;
      $display("FAIL pop2_head got %0d/%0d want 0/5", rd_start, rd_end); end
    tick();
    n_cmp++; if ({empty, rd_valid, rd_end} !== {1'b1, 1'b0, 32'd5}) begin n_bad++;
      $display("FAIL drained got empty=%b v=%b end=%0d want 1 0 5", empty, rd_valid, rd_end); end
    tick();
    n_cmp++; if ({empty, count} !== {1'b1, 4'd0}) begin n_bad++;
      $display("FAIL pop_on_empty got empty=%b count=%0d want 1 0", empty, count); end
    rd_en = 1'b0;
  endtask

  task automatic test_overflow();
    do_clr();
    rdy = 1'b1; match = 1'b1;
    for (int i = 0; i < 9; i++) begin
      startPos = i; endPos = 10 + i;
      tick();
    end
    match = 1'b0;
    n_cmp++; if ({full, overflow, count, total_events} !== {1'b1, 1'b1, 4'd8, 16'd9}) begin n_bad++;
      $display("FAIL overflow_state got full=%b ovf=%b count=%0d tot=%0d want 1 1 8 9", full, overflow, count, total_events); end
    n_cmp++; if ({rd_start, rd_end} !== {32'd0, 32'd10}) begin n_bad++;
      $display("FAIL overflow_head got %0d/%0d want 0/10", rd_start, rd_end); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++; if ({count, overflow, rd_start} !== {4'd7, 1'b1, 32'd1}) begin n_bad++;
      $display("FAIL overflow_sticky got count=%0d ovf=%b head=%0d want 7 1 1", count, overflow, rd_start); end
  endtask

  task automatic test_full_push_pop();
    do_clr();
    rdy = 1'b1; match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      startPos = i; endPos = 20 + i;
      tick();
    end
    startPos = 100; endPos = 200; rd_en = 1'b1;
    tick();
    match = 1'b0; rd_en = 1'b0;
    n_cmp++; if ({count, overflow, full} !== {4'd8, 1'b0, 1'b1}) begin n_bad++;
      $display("FAIL fullpp_state got count=%0d ovf=%b full=%b want 8 0 1", count, overflow, full); end
    for (int k = 0; k < 8; k++) begin
      logic [31:0] es;
      es = (k < 7) ? 32'(k + 1) : 32'd100;
      n_cmp++; if (rd_start !== es) begin n_bad++;
        $display("FAIL fullpp_order[%0d] got %0d want %0d", k, rd_start, es); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_cmp++; if ({empty, rd_end} !== {1'b1, 32'd200}) begin n_bad++;
      $display("FAIL fullpp_drain got empty=%b end=%0d want 1 200", empty, rd_end); end
  endtask

  task automatic test_invalid();
    do_clr();
    rdy = 1'b1; match = 1'b1;
    startPos = ONES; endPos = 5; tick();
    startPos = 5; endPos = 2; tick();
    startPos = 3; endPos = ONES; tick();
    rdy = 1'b0; startPos = 1; endPos = 2; tick();
    n_cmp++; if ({count, total_events, empty} !== {4'd0, 16'd0, 1'b1}) begin n_bad++;
      $display("FAIL invalid_ignored got count=%0d tot=%0d empty=%b want 0 0 1", count, total_events, empty); end
  endtask

  task automatic test_async_reset();
    rdy = 1'b1; match = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      startPos = i; endPos = i;
      tick();
    end
    n_cmp++; if (count !== 4'd3) begin n_bad++;
      $display("FAIL arst_pre got count=%0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({count, overflow, empty, total_events} !== {4'd0, 1'b0, 1'b1, 16'd0}) begin n_bad++;
      $display("FAIL arst_immediate got count=%0d ovf=%b empty=%b tot=%0d want 0 0 1 0", count, overflow, empty, total_events); end
    m_reset();
    #1 reset = 1'b1;
    tick();
    n_cmp++; if ({count, total_events, rd_start} !== {4'd1, 16'd1, 32'd3}) begin n_bad++;
      $display("FAIL arst_held_new got count=%0d tot=%0d start=%0d want 1 1 3", count, total_events, rd_start); end
    match = 1'b0;
  endtask

`ifdef MATCH_LEN_FILTER_EN
  task automatic test_len_filter();
    do_clr();
    rdy = 1'b1; match = 1'b1;
    startPos = 2; endPos = 4; tick();
    startPos = 2; endPos = 5; tick();
    match = 1'b0;
    n_cmp++; if ({count, total_events, rd_start, rd_end} !== {4'd1, 16'd1, 32'd2, 32'd5}) begin n_bad++;
      $display("FAIL len_filter got count=%0d tot=%0d %0d/%0d want 1 1 2/5", count, total_events, rd_start, rd_end); end
  endtask
`endif

  function automatic logic [31:0] rand_pos();
    int r;
    r = $urandom_range(0, 12);
    return (r == 12) ? ONES : 32'(r);
  endfunction

  task automatic test_random();
    logic [87:0] got, expv;
    logic [31:0] es, ee;
    do_clr();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) < 8);
      match = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 4) begin startPos = rand_pos(); endPos = rand_pos(); end
      rd_en = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 199) == 0);
      tick();
      es = (q.size() > 0) ? q[0][63:32] : m_hs;
      ee = (q.size() > 0) ? q[0][31:0] : m_he;
      expv = {q.size() > 0, 4'(q.size()), q.size() == DEPTH, q.size() == 0, m_ovf, 16'(m_tot), es, ee};
      got = {rd_valid, count, full, empty, overflow, total_events, rd_start, rd_end};
      n_cmp++; if (got !== expv) begin n_bad++;
        $display("FAIL random[%0d] got %h want %h", c, got, expv); end
    end
    clr = 1'b0; rd_en = 1'b0; match = 1'b0;
  endtask

  initial begin
    test_reset();
    test_held_match();
    test_changed_end();
    test_overflow();
    test_full_push_pop();
    test_invalid();
    test_async_reset();
`ifdef MATCH_LEN_FILTER_EN
    test_len_filter();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_record_fifo.md
Name: match_record_fifo

Overview:
- Stage directly downstream of the repetition matcher.
- Watches the matcher's match/startPos/endPos outputs and turns each new match report into a single record (start, end).
- Buffers records in a first-word-fall-through FIFO, where the head record is visible on the read port without a prior pop.
- Host or next stage drains the FIFO with a simple pop handshake; the block also keeps a sticky overflow flag and a saturating event counter.

Parameters:
- DEPTH, 8, number of record slots; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- POS_W, 32, width of the start and end position fields.
- MIN_LEN, 1, minimum match length in characters; used only with MATCH_LEN_FILTER_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- clr  input  1  synchronous clear of FIFO, flags and counter.
- rdy  input  1  matcher ready; match inputs are ignored while 0.
- match  input  1  matcher match indication; level signal, may stay high for many cycles.
- startPos  input  POS_W  matcher start position.
- endPos  input  POS_W  matcher end position.
- rd_en  input  1  pop the head record.
- rd_valid  output  1  head record valid; equals !empty.
- rd_start  output  POS_W  head record start position.
- rd_end  output  POS_W  head record end position.
- count  output  ADDR_W+1  number of stored records, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a record was dropped because the FIFO was full.
- total_events  output  16  saturating count of detected events.

Behaviour:
- Reset (reset == 0, asynchronous), and also clr == 1 at a clock edge, puts the block in this state:
  - read/write pointers = 0, count = 0;
  - empty = 1, full = 0, rd_valid = 0;
  - rd_start = rd_end = 0;
  - overflow = 0, total_events = 0;
  - last-event registers: prev_match = 0, last_start = last_end = all-ones.
- clr has priority over push and pop in the same cycle.
- Event detection is registered, one cycle. A cycle is an event when all of the following hold:
  - rdy == 1 and match == 1;
  - either prev_match == 0, or {startPos, endPos} != {last_start, last_end};
  - startPos and endPos are both != all-ones (the matcher's "none" marker);
  - endPos >= startPos, compared unsigned.
- Events that fail the validity checks are silently ignored: no push, no counter change.
- prev_match updates to (rdy & match) every cycle. last_start and last_end update on every event.
- On an event: total_events increments, saturating at 16'hFFFF.
  - Not full, or full with a simultaneous pop: write the record at wr_ptr and advance wr_ptr.
  - Full with no pop: record dropped and overflow set to 1. overflow stays set until reset or clr.
- Record becomes visible on rd_* the cycle after the event edge, so event-to-rd_valid latency is 1 clock.
- Pop: rd_en == 1 and empty == 0 advances rd_ptr at the edge. rd_en on empty is ignored with no side effects.
- Simultaneous push and pop:
  - count is unchanged;
  - when empty, push only (the pop is ignored), count becomes 1;
  - when full, both occur with no overflow.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH. count is kept as a separate register.
- rd_start and rd_end are driven combinationally from the memory at rd_ptr. They hold the last-popped value when empty and are 0 after reset.
- A reset mid-stream discards all stored records. A held match after reset release counts as a new event on the first qualifying cycle.

Optional Feature:
- Macro: MATCH_LEN_FILTER_EN.
- Defined: an event whose length endPos - startPos + 1 is less than MIN_LEN is not pushed and not counted in total_events. It still updates prev_match and last_*, so the same pair is not re-evaluated while held.
- Undefined: no length check, every valid event is pushed, and MIN_LEN is unused.

Test Plan:
- Reset, then rdy=1, match=1 with start=0 and end=3 held for 5 cycles -> exactly one record; count=1, rd_start=0, rd_end=3, total_events=1.
- match held high while end changes 3 -> 5 with start=0 -> second record (0,5); count=2; pop twice gives (0,3) then (0,5), then empty=1.
- 9 distinct events with DEPTH=8 and no pops -> full=1, overflow=1, count=8, total_events=9; first pop returns the first record.
- Full FIFO with an event and rd_en in the same cycle -> count stays 8, overflow stays 0, newest record appears last after 8 pops.
- Invalid inputs: start=all-ones, end<start, or rdy=0 with match=1 -> no push and total_events unchanged. Pulling reset low mid-stream with 3 stored records -> count=0, overflow=0 immediately, without waiting for clk.
- With MATCH_LEN_FILTER_EN and MIN_LEN=4: event (2,4), length 3, is dropped; event (2,5), length 4, is stored; total_events=1.
